// File: rtl/soc_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : soc_mem_arbiter                                           |
// | Desc     : fetch/data two-master arbiter onto the BRAM valid/ready   |
// |            bus; define SOC_ARB_TIMEOUT_EN for the WAIT abort timer.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module soc_mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [31:0]           i_rdata,
   output logic                  i_ack,
   input  logic                  d_req,
   input  logic                  d_rw,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_wdata,
   output logic [31:0]           d_rdata,
   output logic                  d_ack,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [31:0]           m_dwrite,
   output logic                  m_rw,
   output logic                  m_valid,
   input  logic [31:0]           m_dread,
   input  logic                  m_ready,
   output logic                  err
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [31:0] c_abort_data = 32'hDEAD_BEEF;

   generate
      if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
         $error("soc_mem_arbiter: TIMEOUT must be within 1..255");
      end
   endgenerate

   state_t r_state;
   logic   r_last_grant;
   logic   r_grant;
   logic   r_rdy_q;
   logic   w_pick_d;
   logic   w_done;
   logic   w_timeout;

   // Data wins alone, or under contention when fetch was the previous grant.
   assign w_pick_d = d_req & (~i_req | ~r_last_grant);
   // Only a rising ready counts; r_rdy_q is preloaded high at issue.
   assign w_done   = m_ready & ~r_rdy_q;

`ifdef SOC_ARB_TIMEOUT_EN
   localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);
   logic [7:0] r_cnt;
   assign w_timeout = (r_cnt == c_timeout_last);
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_rdy_q      <= 1'b1;
         m_addr       <= '0;
         m_dwrite     <= '0;
         m_rw         <= 1'b0;
         m_valid      <= 1'b0;
         i_rdata      <= '0;
         i_ack        <= 1'b0;
         d_rdata      <= '0;
         d_ack        <= 1'b0;
`ifdef SOC_ARB_TIMEOUT_EN
         r_cnt        <= '0;
         err          <= 1'b0;
`endif
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
`ifdef SOC_ARB_TIMEOUT_EN
         err   <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               m_valid <= 1'b0;
               if (i_req | d_req) begin
                  r_grant      <= w_pick_d;
                  r_last_grant <= w_pick_d;
                  m_addr       <= w_pick_d ? d_addr : i_addr;
                  m_rw         <= w_pick_d & d_rw;
                  m_dwrite     <= (w_pick_d & d_rw) ? d_wdata : 32'd0;
                  m_valid      <= 1'b1;
                  r_rdy_q      <= 1'b1;
                  r_state      <= S_WAIT;
`ifdef SOC_ARB_TIMEOUT_EN
                  r_cnt        <= '0;
`endif
               end
            end
            S_WAIT: begin
               r_rdy_q <= m_ready;
`ifdef SOC_ARB_TIMEOUT_EN
               r_cnt   <= r_cnt + 8'd1;
`endif
               if (w_done | w_timeout) begin
                  m_valid <= 1'b0;
                  r_state <= S_IDLE;
                  if (r_grant) begin
                     d_ack   <= 1'b1;
                     d_rdata <= w_done ? (m_rw ? 32'd0 : m_dread) : c_abort_data;
                  end else begin
                     i_ack   <= 1'b1;
                     i_rdata <= w_done ? m_dread : c_abort_data;
                  end
`ifdef SOC_ARB_TIMEOUT_EN
                  err     <= ~w_done;
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
